// File: rtl/dcf77_pulse_decoder.sv
// DCF77 pulse decoder: slices Goertzel carrier power into a level with hysteresis,
// measures low-pulse widths in blocks, classifies second marks, detects the minute
// marker and assembles a 59-bit time frame.
module dcf77_pulse_decoder #(
    parameter int unsigned THRESH_LO  = 1000,
    parameter int unsigned THRESH_HI  = 2000,
    parameter int unsigned MIN_LOW    = 100,
    parameter int unsigned BIT_SPLIT  = 375,
    parameter int unsigned MAX_LOW    = 625,
    parameter int unsigned MARKER_GAP = 4250
) (
    input  logic               clock_sample,
    input  logic               reset_n,
    input  logic               power_valid,
    input  logic signed [31:0] power,
    output logic               carrier_low,
    output logic               bit_valid,
    output logic               bit_value,
    output logic               frame_valid,
    output logic [58:0]        frame,
    output logic [5:0]         bit_count,
    output logic               synced,
    output logic               error
);

    localparam logic [31:0] ThreshLo  = 32'(THRESH_LO);
    localparam logic [31:0] ThreshHi  = 32'(THRESH_HI);
    localparam logic [12:0] MinLow    = 13'(MIN_LOW);
    localparam logic [12:0] BitSplit  = 13'(BIT_SPLIT);
    localparam logic [12:0] MaxLow    = 13'(MAX_LOW);
    localparam logic [12:0] MarkerGap = 13'(MARKER_GAP);
    localparam logic [12:0] DurMax    = 13'h1fff;
    localparam logic [5:0]  FrameBits = 6'd59;

    typedef enum logic {StUnsync, StSync} sync_state_e;

    sync_state_e state_q, state_d;
    logic [12:0] dur_q, dur_d;
    logic [58:0] buffer_q, buffer_d;
    logic        carrier_low_d;
    logic        bit_valid_d;
    logic        bit_value_d;
    logic        frame_valid_d;
    logic [58:0] frame_d;
    logic [5:0]  bit_count_d;
    logic        error_d;
    logic        pulse_bit;
    logic [31:0] power_mag;

    // Negative power clamps to zero so it always reads as a weak carrier.
    assign power_mag = power[31] ? 32'd0 : $unsigned(power);
    assign synced    = (state_q == StSync);

    // Next-state: slicer, duration counter, transition decode and sync FSM.
    always_comb begin
        state_d       = state_q;
        dur_d         = dur_q;
        buffer_d      = buffer_q;
        carrier_low_d = carrier_low;
        bit_valid_d   = 1'b0;
        bit_value_d   = bit_value;
        frame_valid_d = 1'b0;
        frame_d       = frame;
        bit_count_d   = bit_count;
        error_d       = 1'b0;
        pulse_bit     = 1'b0;

        if (power_valid) begin
            if (!carrier_low && (power_mag < ThreshLo)) begin
                carrier_low_d = 1'b1;
            end else if (carrier_low && (power_mag > ThreshHi)) begin
                carrier_low_d = 1'b0;
            end

            if (carrier_low_d != carrier_low) begin
                dur_d = 13'd1;
                if (!carrier_low) begin
                    // High->low: dur_q is the length of the high run just ended.
                    if (dur_q >= MarkerGap) begin
                        if (state_q == StSync) begin
                            if (bit_count == FrameBits) begin
                                frame_valid_d = 1'b1;
                                frame_d       = buffer_q;
                            end else begin
                                error_d = 1'b1;
                            end
                        end
                        bit_count_d = 6'd0;
                        state_d     = StSync;
                    end
                end else begin
                    // Low->high: dur_q is the low-pulse width.
                    if ((dur_q < MinLow) || (dur_q > MaxLow)) begin
                        error_d     = 1'b1;
                        state_d     = StUnsync;
                        bit_count_d = 6'd0;
                    end else begin
                        pulse_bit = (dur_q >= BitSplit);
                        if ((state_q == StSync) && (bit_count == FrameBits)) begin
                            // A 60th mark: the marker was missed. Error wins over bit_valid.
                            error_d     = 1'b1;
                            state_d     = StUnsync;
                            bit_count_d = 6'd0;
                        end else begin
                            bit_valid_d = 1'b1;
                            bit_value_d = pulse_bit;
                            if (state_q == StSync) begin
                                buffer_d[bit_count] = pulse_bit;
                                bit_count_d         = bit_count + 6'd1;
                            end
                        end
                    end
                end
            end else if (dur_q != DurMax) begin
                dur_d = dur_q + 13'd1;
            end
        end
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clock_sample) begin
        if (!reset_n) begin
            state_q     <= StUnsync;
            dur_q       <= 13'd0;
            buffer_q    <= 59'd0;
            carrier_low <= 1'b0;
            bit_valid   <= 1'b0;
            bit_value   <= 1'b0;
            frame_valid <= 1'b0;
            frame       <= 59'd0;
            bit_count   <= 6'd0;
            error       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dur_q       <= dur_d;
            buffer_q    <= buffer_d;
            carrier_low <= carrier_low_d;
            bit_valid   <= bit_valid_d;
            bit_value   <= bit_value_d;
            frame_valid <= frame_valid_d;
            frame       <= frame_d;
            bit_count   <= bit_count_d;
            error       <= error_d;
        end
    end

endmodule

// File: tb/tb_dcf77_pulse_decoder.sv
// Testbench for dcf77_pulse_decoder. Durations are scaled by 1/10 through the
// parameters so complete minutes fit in a short run.
module tb_dcf77_pulse_decoder;

    localparam int unsigned MinLowP    = 10;
    localparam int unsigned BitSplitP  = 38;
    localparam int unsigned MaxLowP    = 62;
    localparam int unsigned MarkerGapP = 425;

    logic               clock_sample;
    logic               reset_n;
    logic               power_valid;
    logic signed [31:0] power;
    logic               carrier_low;
    logic               bit_valid;
    logic               bit_value;
    logic               frame_valid;
    logic [58:0]        frame;
    logic [5:0]         bit_count;
    logic               synced;
    logic               error;

    dcf77_pulse_decoder #(
        .THRESH_LO  (1000),
        .THRESH_HI  (2000),
        .MIN_LOW    (MinLowP),
        .BIT_SPLIT  (BitSplitP),
        .MAX_LOW    (MaxLowP),
        .MARKER_GAP (MarkerGapP)
    ) dut (
        .clock_sample (clock_sample),
        .reset_n      (reset_n),
        .power_valid  (power_valid),
        .power        (power),
        .carrier_low  (carrier_low),
        .bit_valid    (bit_valid),
        .bit_value    (bit_value),
        .frame_valid  (frame_valid),
        .frame        (frame),
        .bit_count    (bit_count),
        .synced       (synced),
        .error        (error)
    );

    initial clock_sample = 1'b0;
    always #5 clock_sample = ~clock_sample;

    int n_tests = 0;
    int n_fail  = 0;

    // Strobe monitor, sampled on the falling edge.
    int          n_bits  = 0;
    int          n_err   = 0;
    int          n_frm   = 0;
    int          n_trans = 0;
    int          n_excl  = 0;
    logic        prev_low = 1'b0;
    logic        bit_log [64];
    logic [58:0] last_frame = '0;

    always @(negedge clock_sample) begin
        if (carrier_low !== prev_low) n_trans++;
        prev_low = carrier_low;
        if (reset_n) begin
            if (bit_valid) begin
                if (n_bits < 64) bit_log[n_bits] = bit_value;
                n_bits++;
            end
            if (error) n_err++;
            if (frame_valid) begin
                n_frm++;
                last_frame = frame;
            end
            if (error && (bit_valid || frame_valid)) n_excl++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        n_bits = 0;
        n_err  = 0;
        n_frm  = 0;
    endtask

    task automatic run(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            power       = p;
            power_valid = 1'b1;
            @(posedge clock_sample);
            #1;
        end
    endtask

    // One second mark: low for w blocks, high for the rest of the period.
    task automatic mark(input int w, input int period);
        run(500, w);
        run(5000, period - w);
    endtask

    task automatic settle();
        @(negedge clock_sample);
        #1;
    endtask

    task automatic reset_dut();
        reset_n     = 1'b0;
        power_valid = 1'b0;
        power       = 5000;
        repeat (3) @(posedge clock_sample);
        #1;
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic               pv;
        logic signed [31:0] pw;
        logic               exp_low;
    } vec_t;

    vec_t        vecs [14];
    logic [58:0] pat;

    initial begin
        vecs[0]  = '{1'b1, 32'sd500,  1'b1};
        vecs[1]  = '{1'b1, 32'sd500,  1'b1};
        vecs[2]  = '{1'b1, 32'sd1500, 1'b1};
        vecs[3]  = '{1'b1, 32'sd1500, 1'b1};
        vecs[4]  = '{1'b1, 32'sd2000, 1'b1};
        vecs[5]  = '{1'b1, 32'sd2001, 1'b0};
        vecs[6]  = '{1'b0, 32'sd500,  1'b0};
        vecs[7]  = '{1'b1, 32'sd1500, 1'b0};
        vecs[8]  = '{1'b1, 32'sd1000, 1'b0};
        vecs[9]  = '{1'b1, 32'sd999,  1'b1};
        vecs[10] = '{1'b1, -32'sd7,   1'b1};
        vecs[11] = '{1'b1, 32'sd3000, 1'b0};
        vecs[12] = '{1'b1, -32'sd7,   1'b1};
        vecs[13] = '{1'b1, 32'sd2500, 1'b0};
        pat = 59'h2AAAAAAAAAAAAAA;

        // Reset with strobes toggling and strong carrier.
        reset_n     = 1'b0;
        power       = 5000;
        power_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            power_valid = i[0];
            @(posedge clock_sample);
            #1;
        end
        chk("rst_carrier_low", 64'(carrier_low), 64'd0);
        chk("rst_bit_valid",   64'(bit_valid),   64'd0);
        chk("rst_bit_value",   64'(bit_value),   64'd0);
        chk("rst_frame_valid", 64'(frame_valid), 64'd0);
        chk("rst_frame",       64'(frame),       64'd0);
        chk("rst_bit_count",   64'(bit_count),   64'd0);
        chk("rst_synced",      64'(synced),      64'd0);
        chk("rst_error",       64'(error),       64'd0);
        reset_n = 1'b1;
        settle();
        n_trans = 0;

        // Slicer and hysteresis vectors.
        for (int i = 0; i < 14; i++) begin
            power_valid = vecs[i].pv;
            power       = vecs[i].pw;
            @(posedge clock_sample);
            #1;
            chk($sformatf("slice_vec%0d", i), 64'(carrier_low), 64'(vecs[i].exp_low));
        end
        settle();
        chk("slice_transitions", 64'(n_trans), 64'd6);

        // Bit classification after a marker.
        reset_dut();
        run(5000, 500);
        clear_mon();
        mark(25, 250);
        mark(37, 262);
        mark(38, 263);
        mark(62, 287);
        settle();
        chk("cls_nbits", 64'(n_bits), 64'd4);
        chk("cls_bits", {60'd0, bit_log[3], bit_log[2], bit_log[1], bit_log[0]}, 64'b1100);
        chk("cls_bit_count", 64'(bit_count), 64'd4);
        chk("cls_synced", 64'(synced), 64'd1);
        chk("cls_err", 64'(n_err), 64'd0);

        // Full frame.
        reset_dut();
        run(5000, 500);
        clear_mon();
        for (int i = 0; i < 59; i++) mark(pat[i] ? 50 : 20, 250);
        run(5000, 300);
        run(500, 1);
        settle();
        chk("frm_count", 64'(n_frm), 64'd1);
        chk("frm_value", 64'(last_frame), 64'(pat));
        chk("frm_nbits", 64'(n_bits), 64'd59);
        chk("frm_bit_count", 64'(bit_count), 64'd0);
        chk("frm_err", 64'(n_err), 64'd0);
        chk("frm_synced", 64'(synced), 64'd1);

        // Glitch: too-short low while synced.
        run(500, 19);
        run(5000, 231);
        clear_mon();
        run(500, 5);
        run(5000, 450);
        chk("gli_err", 64'(n_err), 64'd1);
        chk("gli_synced", 64'(synced), 64'd0);
        chk("gli_nbits", 64'(n_bits), 64'd0);
        run(500, 20);
        run(5000, 230);
        chk("gli_no_frame", 64'(n_frm), 64'd0);
        chk("gli_resync", 64'(synced), 64'd1);

        // Overlong low while synced.
        clear_mon();
        run(500, 70);
        run(5000, 450);
        chk("long_err", 64'(n_err), 64'd1);
        chk("long_synced", 64'(synced), 64'd0);
        chk("long_nbits", 64'(n_bits), 64'd0);
        run(500, 20);
        run(5000, 230);
        chk("long_no_frame", 64'(n_frm), 64'd0);

        // Count mismatch: marker, 58 bits, marker.
        reset_dut();
        run(5000, 500);
        clear_mon();
        for (int i = 0; i < 58; i++) mark(20, 250);
        run(5000, 300);
        run(500, 1);
        settle();
        chk("mis_err", 64'(n_err), 64'd1);
        chk("mis_no_frame", 64'(n_frm), 64'd0);
        chk("mis_synced", 64'(synced), 64'd1);
        chk("mis_bit_count", 64'(bit_count), 64'd0);

        // Overflow: 60 marks with no marker; the marker mark above is the first.
        clear_mon();
        run(500, 19);
        run(5000, 230);
        for (int i = 0; i < 58; i++) mark(50, 250);
        chk("ovf_pre_count", 64'(bit_count), 64'd59);
        chk("ovf_pre_err", 64'(n_err), 64'd0);
        run(500, 20);
        run(5000, 10);
        settle();
        chk("ovf_err", 64'(n_err), 64'd1);
        chk("ovf_synced", 64'(synced), 64'd0);
        chk("ovf_bit_count", 64'(bit_count), 64'd0);
        chk("ovf_nbits", 64'(n_bits), 64'd59);

        chk("strobe_exclusive", 64'(n_excl), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dcf77_pulse_decoder.md
# dcf77_pulse_decoder

Consumes the per-block carrier power produced by the 77.5 kHz Goertzel stage, one value per 520-sample block (2500 blocks/s at 1.3 MHz). It slices the power into a carrier-high/low level with hysteresis and measures low-pulse widths in blocks to classify DCF77 second marks as 0 or 1. It also detects the minute marker (missing second 59) and assembles a 59-bit time frame, flagging timing violations. It runs entirely in the clock_sample domain; the power strobe arrives already synchronised to clock_sample.

## Interface
Parameters:
- THRESH_LO, 1000: carrier goes low when power < THRESH_LO.
- THRESH_HI, 2000: carrier returns high when power > THRESH_HI. THRESH_HI ≥ THRESH_LO.
- MIN_LOW, 100: shortest legal low pulse, in blocks (40 ms).
- BIT_SPLIT, 375: low pulse ≥ BIT_SPLIT decodes as 1, shorter decodes as 0 (150 ms).
- MAX_LOW, 625: longest legal low pulse, in blocks (250 ms).
- MARKER_GAP, 4250: high run ≥ MARKER_GAP is the minute marker (1.7 s). All duration parameters < 8191.

Ports:
- clock_sample  in  1: sample clock, 1.3 MHz.
- reset_n  in  1: reset, synchronous, active-low.
- power_valid  in  1: single-cycle strobe; power is valid this cycle.
- power  in  32 (signed): block power; negative values are treated as 0.
- carrier_low  out  1: sliced carrier level, 1 = reduced carrier.
- bit_valid  out  1: one-cycle strobe, decoded bit available.
- bit_value  out  1: decoded bit, qualified by bit_valid.
- frame_valid  out  1: one-cycle strobe, complete frame on frame.
- frame  out  59: frame[n] = bit of second n. Held until the next frame.
- bit_count  out  6: bits collected since the last marker, 0..59.
- synced  out  1: a minute marker has been seen since the last error or reset.
- error  out  1: one-cycle strobe on any timing violation.

## Operation
- All state advances only on cycles with power_valid=1. Other cycles hold state, and strobes return to 0.
- Slicer: if carrier_low=0 and power < THRESH_LO, set carrier_low. If carrier_low=1 and power > THRESH_HI, clear it. Otherwise hold.
- Duration counter dur (13 bits):
  - On a level change, dur ← 1.
  - With no level change, dur ← dur+1, saturating at 8191.
  - Transition decisions use dur before this update, i.e. the length of the level just ended.
- High→low transition (start of a second mark):
  - If dur ≥ MARKER_GAP, this is the minute marker.
    - If synced=1 and bit_count=59: pulse frame_valid and load frame from the shift buffer.
    - If synced=1 and bit_count≠59: pulse error and discard the frame; synced stays 1.
    - In all cases: bit_count ← 0, synced ← 1.
  - If dur < MARKER_GAP: no action.
- Low→high transition (end of a second mark), with L = dur:
  - If L < MIN_LOW or L > MAX_LOW: pulse error, synced ← 0, bit_count ← 0.
  - Otherwise bit = (L ≥ BIT_SPLIT); pulse bit_valid with bit_value = bit, whether synced or not.
    - If synced=1 and bit_count < 59: buffer[bit_count] ← bit, bit_count ← bit_count+1.
    - If synced=1 and bit_count = 59 (a 60th bit): pulse error, synced ← 0, bit_count ← 0.
- Sync states: UNSYNC (reset, after an error) → SYNC on a minute marker. SYNC → UNSYNC on a pulse-width error or bit overflow. A wrong-count marker keeps SYNC.
- Buffer bits not written in the current minute keep stale values. Only frame_valid qualifies frame.

## Timing
- Reset values: carrier_low=0, bit_valid=0, bit_value=0, frame_valid=0, frame=0, bit_count=0, synced=0, error=0. Internal: dur=0, buffer=0.
- Synchronous reset mid-frame discards all progress. The first frame after reset needs marker + 59 bits + marker.
- Latency: strobes assert in the clock_sample cycle after the power_valid cycle that caused the transition, for exactly one cycle.
- carrier_low updates in that same following cycle.
- error and frame_valid are mutually exclusive. error and bit_valid are mutually exclusive.
- Back-to-back power_valid strobes are legal, with a minimum spacing of 1 cycle.

## Test plan
- Reset:
  - Stimulus: hold reset_n=0 for 5 cycles with power_valid toggling and power=5000.
  - Required: every output 0.
  - Then: release reset, drive 10 blocks of power=500.
  - Required: carrier_low=1 one cycle after the first block.
- Hysteresis:
  - Stimulus: carrier low, then blocks of power=1500.
  - Required: carrier_low stays 1.
  - Then: power=2001.
  - Required: carrier_low clears, and there is exactly one transition.
- Bit classification (after a marker):
  - Stimulus: low runs of 250, 374, 375 and 625 blocks, each followed by a high run of 2250 blocks.
  - Required: bit_value 0, 0, 1, 1 with four bit_valid pulses, and bit_count reaching 4.
- Full frame:
  - Stimulus: 5000 high blocks; 59 marks encoding the pattern 0x2AAAAAAAAAAAAAA (bit0=0); 4500 high blocks.
  - Required: one frame_valid with frame=0x2AAAAAAAAAAAAAA, bit_count=0 afterwards, and error never asserted.
- Glitch and overlong pulses:
  - Stimulus: a 50-block low while synced.
  - Required: error pulse, synced=0, no bit_valid, and no frame_valid at the next marker.
  - Stimulus: repeat with a 700-block low.
  - Required: the same response.
- Count mismatch and overflow:
  - Stimulus: marker, 58 bits, marker.
  - Required: error pulse, no frame_valid, synced=1.
  - Stimulus: 60 marks without a marker.
  - Required: error on the 60th mark, and synced=0.
